jellyvl_etherneco_payload_replacer: RTL and testbench
=====================================================

// Module: jellyvl_etherneco_payload_replacer
// PURPOSE
//  Shares the packet-rx replace port between NUM_SLOTS requesters. Each slot owns a payload byte window.
//  Slots are matched on rx_type. While a matching packet streams through, the block pulls bytes from the
//  window owner's stream and drives replace_data/replace_valid, aligned to the rx forward path delay.
//  Sits beside jellyvl_etherneco_packet_rx, between its payload_*/rx_* outputs and its replace_* inputs.
// PARAMETERS
//  NUM_SLOTS        4  number of requester slots (1..16)
//  REPLACE_LATENCY  1  cycles from payload_valid to replace_valid; equals rx REPLACE_DELAY+1, must be >=1
// PORTS
//  clk            in   1         clock
//  rst            in   1         reset, synchronous, active-low
//  slot_enable    in   N         per-slot enable
//  slot_type      in   N*8       rx_type value the slot responds to
//  slot_offset    in   N*16      first payload_pos of the window
//  slot_size      in   N*16      window length in bytes; 0 = never hits
//  s_slot_data    in   N*8       replacement byte per slot
//  s_slot_valid   in   N         slot has a byte ready
//  s_slot_ready   out  N         byte consumed this cycle
//  rx_start       in   1         from packet_rx
//  rx_end         in   1         from packet_rx (CRC good)
//  rx_error       in   1         from packet_rx
//  rx_type        in   8         from packet_rx; stable during payload
//  payload_first  in   1         from packet_rx
//  payload_pos    in   16        from packet_rx
//  payload_valid  in   1         from packet_rx
//  replace_data   out  8         to packet_rx
//  replace_valid  out  1         to packet_rx
//  slot_done      out  N         1-cycle pulse: packet ended good and slot had >=1 hit
//  slot_abort     out  N         1-cycle pulse: packet errored and slot had >=1 hit
//  slot_underrun  out  N         sticky: window hit while s_slot_valid=0; cleared by rx_start
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, delay line empty, shadow config invalid.
//  Config shadow:
//   - On payload_valid & payload_first, slot_enable/type/offset/size are latched for the packet.
//   - The hit test in that same cycle uses the live inputs. Mid-packet config changes take effect next packet.
//  Hit test for slot k, per payload_valid cycle:
//   - en_k & type_k==rx_type & pos>=off_k & (pos-off_k)<size_k.
//   - Arithmetic is 17-bit unsigned, so off_k+size_k beyond 0xFFFF does not wrap.
//  Arbitration: when windows overlap, the lowest index wins. Only the winner sees ready. No state, no fairness.
//  Handshake:
//   - s_slot_ready[k] = payload_valid & win_k, combinational. It must not depend on s_slot_valid[k].
//   - Transfer when ready&valid: stage byte = s_slot_data[k], stage valid = 1.
//   - Hit with valid=0: stage valid = 0, so the original byte passes through; set slot_underrun[k].
//  Latency:
//   - The stage is pushed through a REPLACE_LATENCY-deep shift register.
//   - replace_valid/replace_data appear exactly REPLACE_LATENCY cycles after the payload_valid cycle.
//   - Cycles without a payload byte push valid=0.
//  Packet tracking: hit_seen[k] is set on any hit (including underrun) and cleared on rx_start.
//  Completion:
//   - rx_end: slot_done = hit_seen, pulsed 1 cycle later; hit_seen cleared.
//   - rx_error: slot_abort = hit_seen, pulsed 1 cycle later; hit_seen cleared; delay line flushed (valid=0).
//  Simultaneous events:
//   - rx_error with rx_start (new frame during error): error handling first, then start clears underrun.
//   - rx_end with rx_error cannot both be 1; if they are, rx_error wins.
//  Outside payload: s_slot_ready=0 and no hit, even if payload_pos is X.
//  Reset mid-packet: everything returns to reset values. Remaining packet bytes pass unreplaced.
// STRUCTURE
//  Shared package: jellyvl_etherneco_pkg
//   - t_length = logic[15:0] and t_type = logic[7:0]
//   - t_slot_cfg struct {enable, type, offset, size}, reused by the packet_tx side
//  Sub-module: jellyvl_data_delay (t_data=logic[8:0], LATENCY=REPLACE_LATENCY-1) after the stage register.
//   - Flush is done by gating m_valid with an epoch bit.
//  Priority pick: local function, no sub-module.
// TESTING
//  1. slot0 type=0x10, off=4, size=3, data 0xA0,0xA1,0xA2 preloaded; type=0x10, 8-byte payload
//     -> replace_valid at pos 4..6 (+LATENCY) with A0..A2, s_slot_ready x3, slot_done[0] after rx_end.
//  2. slot0 off=0 size=4, slot1 off=2 size=4, same type
//     -> pos0-3 from slot0, pos4-5 from slot1; slot1 never ready at pos2-3.
//  3. slot0 valid dropped at pos5 of window 4..6
//     -> no replace at pos5, slot_underrun[0]=1 until next rx_start.
//  4. rx_error asserted while window bytes are in the delay line
//     -> no replace_valid after the error cycle; slot_abort[0] pulses; slot_done stays 0.
//  5. type mismatch (0x11), size=0, and off=0xFFFE size=4 at pos 0xFFFF
//     -> no hits in the first two; last hits at 0xFFFE,0xFFFF, no wrap.
//  6. rst=0 for 1 cycle mid-window
//     -> all outputs 0 next cycle; later packets behave as in test 1.

Source files
------------

// File: rtl/jellyvl_etherneco_pkg.sv
// Shared Etherneco types.
//   t_length   : 16-bit byte position / length
//   t_type     : 8-bit packet type
//   t_slot_cfg : per-slot window config {enable, ptype, offset, size}; also used by the tx side
//   in_window  : true when pos lies in [offset, offset+size), evaluated in 17 bits so no wrap
package jellyvl_etherneco_pkg;

  typedef logic [15:0] t_length;
  typedef logic [7:0]  t_type;

  typedef struct packed {
    logic    enable;
    t_type   ptype;
    t_length offset;
    t_length size;
  } t_slot_cfg;

  function automatic logic in_window(input t_length pos, input t_length offset,
                                     input t_length size);
    logic [16:0] diff;
    diff = {1'b0, pos} - {1'b0, offset};
    // diff[16] set means pos < offset; size == 0 can never satisfy the compare
    return !diff[16] && (diff < {1'b0, size});
  endfunction

endpackage

// File: rtl/jellyvl_data_delay.sv
// Fixed-latency valid/data delay line.
//   clk, rst (sync, active-low)
//   s_data/s_valid : input beat, pushed every cycle
//   m_data/m_valid : the same beat LATENCY cycles later (LATENCY = 0 is a plain wire)
module jellyvl_data_delay #(
  parameter int unsigned LATENCY = 1,
  parameter type         t_data  = logic [8:0]
) (
  input  logic  clk,
  input  logic  rst,
  input  t_data s_data,
  input  logic  s_valid,
  output t_data m_data,
  output logic  m_valid
);

  if (LATENCY == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign m_data         = s_data;
    assign m_valid        = s_valid;
  end else begin : g_shift
    t_data              data_q [LATENCY];
    logic [LATENCY-1:0] valid_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < LATENCY; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= s_valid;
        data_q[0]  <= s_data;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign m_data  = data_q[LATENCY-1];
    assign m_valid = valid_q[LATENCY-1];
  end

endmodule

// File: rtl/jellyvl_etherneco_payload_replacer.sv
// Shares the packet_rx replace port between NUM_SLOTS requesters, each owning a payload window.
//   slot_enable/type/offset/size : per-slot window config, shadowed on the first payload byte
//   s_slot_data/valid/ready      : per-slot replacement byte stream (ready = byte consumed)
//   rx_start/end/error, rx_type  : packet framing from packet_rx
//   payload_first/pos/valid      : payload byte strobe from packet_rx
//   replace_data/valid           : replacement byte, REPLACE_LATENCY cycles after payload_valid
//   slot_done/abort              : 1-cycle pulse on good/errored packet end if the slot hit
//   slot_underrun                : sticky, window hit with no byte ready; cleared by rx_start
module jellyvl_etherneco_payload_replacer
  import jellyvl_etherneco_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned REPLACE_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SLOTS-1:0]   slot_enable,
  input  logic [NUM_SLOTS*8-1:0] slot_type,
  input  logic [NUM_SLOTS*16-1:0] slot_offset,
  input  logic [NUM_SLOTS*16-1:0] slot_size,
  input  logic [NUM_SLOTS*8-1:0] s_slot_data,
  input  logic [NUM_SLOTS-1:0]   s_slot_valid,
  output logic [NUM_SLOTS-1:0]   s_slot_ready,
  input  logic                   rx_start,
  input  logic                   rx_end,
  input  logic                   rx_error,
  input  t_type                  rx_type,
  input  logic                   payload_first,
  input  t_length                payload_pos,
  input  logic                   payload_valid,
  output logic [7:0]             replace_data,
  output logic                   replace_valid,
  output logic [NUM_SLOTS-1:0]   slot_done,
  output logic [NUM_SLOTS-1:0]   slot_abort,
  output logic [NUM_SLOTS-1:0]   slot_underrun
);

  typedef logic [8:0] t_stage;  // {epoch, byte}

  t_slot_cfg [NUM_SLOTS-1:0] cfg_live, cfg_use, cfg_q;
  logic                      cfg_valid_q;
  logic                      cfg_ok;
  logic [NUM_SLOTS-1:0]      hit, win;
  logic [7:0]                sel_data;
  logic                      sel_valid;

  logic                      stage_valid_q;
  t_stage                    stage_data_q;
  logic                      epoch_q;
  logic [NUM_SLOTS-1:0]      hit_seen_q, done_q, abort_q, underrun_q;

  t_stage                    dly_data;
  logic                      dly_valid;

  function automatic logic [NUM_SLOTS-1:0] pick_lowest(input logic [NUM_SLOTS-1:0] req);
    logic [NUM_SLOTS-1:0] grant;
    grant = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (req[k] && grant == '0) grant[k] = 1'b1;
    end
    return grant;
  endfunction

  always_comb begin
    cfg_live = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      cfg_live[k].enable = slot_enable[k];
      cfg_live[k].ptype  = slot_type[k*8 +: 8];
      cfg_live[k].offset = slot_offset[k*16 +: 16];
      cfg_live[k].size   = slot_size[k*16 +: 16];
    end
    // The first byte is tested against live config, later bytes against the shadow
    cfg_use = payload_first ? cfg_live : cfg_q;
    // Gating on rst keeps ready low while reset is held; invalid shadow means no hits
    cfg_ok  = rst && payload_valid && (payload_first || cfg_valid_q);
    hit     = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      hit[k] = cfg_ok && cfg_use[k].enable && (cfg_use[k].ptype == rx_type) &&
               in_window(payload_pos, cfg_use[k].offset, cfg_use[k].size);
    end
    win = pick_lowest(hit);
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (win[k]) begin
        sel_data  = s_slot_data[k*8 +: 8];
        sel_valid = s_slot_valid[k];
      end
    end
  end

  assign s_slot_ready = win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q         <= '0;
      cfg_valid_q   <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      epoch_q       <= 1'b0;
      hit_seen_q    <= '0;
      done_q        <= '0;
      abort_q       <= '0;
      underrun_q    <= '0;
    end else begin
      if (payload_valid && payload_first) begin
        cfg_q       <= cfg_live;
        cfg_valid_q <= 1'b1;
      end
      stage_valid_q <= sel_valid && !rx_error;
      stage_data_q  <= {epoch_q, sel_data};
      // Toggling the epoch orphans every beat already in the delay line
      if (rx_error) epoch_q <= ~epoch_q;
      done_q     <= (rx_end && !rx_error) ? (hit_seen_q | hit) : '0;
      abort_q    <= rx_error ? (hit_seen_q | hit) : '0;
      hit_seen_q <= (rx_start || rx_end || rx_error) ? '0 : (hit_seen_q | hit);
      underrun_q <= (rx_start ? '0 : underrun_q) | (win & ~s_slot_valid);
    end
  end

  jellyvl_data_delay #(
    .LATENCY (REPLACE_LATENCY - 1),
    .t_data  (t_stage)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .s_data  (stage_data_q),
    .s_valid (stage_valid_q),
    .m_data  (dly_data),
    .m_valid (dly_valid)
  );

  assign replace_valid = dly_valid && (dly_data[8] == epoch_q);
  assign replace_data  = replace_valid ? dly_data[7:0] : 8'h00;
  assign slot_done     = done_q;
  assign slot_abort    = abort_q;
  assign slot_underrun = underrun_q;

endmodule

// File: tb/tb_jellyvl_etherneco_payload_replacer.sv
// Directed bench for jellyvl_etherneco_payload_replacer with a replace-output scoreboard.
module tb_jellyvl_etherneco_payload_replacer;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    slot_enable;
  logic [N*8-1:0]  slot_type;
  logic [N*16-1:0] slot_offset;
  logic [N*16-1:0] slot_size;
  logic [N*8-1:0]  s_slot_data;
  logic [N-1:0]    s_slot_valid;
  logic [N-1:0]    s_slot_ready;
  logic            rx_start, rx_end, rx_error;
  logic [7:0]      rx_type;
  logic            payload_first;
  logic [15:0]     payload_pos;
  logic            payload_valid;
  logic [7:0]      replace_data;
  logic            replace_valid;
  logic [N-1:0]    slot_done, slot_abort, slot_underrun;

  jellyvl_etherneco_payload_replacer #(
    .NUM_SLOTS       (N),
    .REPLACE_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .slot_enable   (slot_enable),
    .slot_type     (slot_type),
    .slot_offset   (slot_offset),
    .slot_size     (slot_size),
    .s_slot_data   (s_slot_data),
    .s_slot_valid  (s_slot_valid),
    .s_slot_ready  (s_slot_ready),
    .rx_start      (rx_start),
    .rx_end        (rx_end),
    .rx_error      (rx_error),
    .rx_type       (rx_type),
    .payload_first (payload_first),
    .payload_pos   (payload_pos),
    .payload_valid (payload_valid),
    .replace_data  (replace_data),
    .replace_valid (replace_valid),
    .slot_done     (slot_done),
    .slot_abort    (slot_abort),
    .slot_underrun (slot_underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  int         due_q[$];
  bit         v_q[$];
  logic [7:0] d_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one expected replace beat per cycle
  always @(negedge clk) begin
    if (mon_en) begin
      logic       ev;
      logic [7:0] ed;
      ev = 1'b0;
      ed = 8'h00;
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front());
        void'(v_q.pop_front());
        void'(d_q.pop_front());
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        ev = v_q.pop_front();
        ed = d_q.pop_front();
        void'(due_q.pop_front());
      end
      chk("replace_valid", 32'(replace_valid), 32'(ev));
      if (ev) chk("replace_data", 32'(replace_data), 32'(ed));
    end
  end

  // One clock: drive payload strobe, push expected replace beat, check ready mid-cycle
  task automatic tick(input logic pv, input logic pf, input logic [15:0] pos,
                      input logic ev, input logic [7:0] ed, input logic [N-1:0] er);
    payload_valid = pv;
    payload_first = pf;
    payload_pos   = pv ? pos : 16'hxxxx;
    due_q.push_back(cyc + int'(LAT));
    v_q.push_back(ev);
    d_q.push_back(ed);
    // Error or reset drops every beat not yet presented
    if (rx_error || !rst) begin
      foreach (due_q[i]) if (due_q[i] > cyc) v_q[i] = 1'b0;
    end
    @(negedge clk);
    chk("s_slot_ready", 32'(s_slot_ready), 32'(er));
    @(posedge clk);
    #1;
    rx_start = 1'b0;
    rx_end   = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 16'h0, 1'b0, 8'h00, '0);
  endtask

  task automatic set_slot(input int k, input logic en, input logic [7:0] ty,
                          input logic [15:0] off, input logic [15:0] sz);
    slot_enable[k]          = en;
    slot_type[k*8 +: 8]     = ty;
    slot_offset[k*16 +: 16] = off;
    slot_size[k*16 +: 16]   = sz;
  endtask

  task automatic run_basic(input string tag);
    set_slot(0, 1'b1, 8'h10, 16'd4, 16'd3);
    slot_enable[N-1:1] = '0;
    rx_type      = 8'h10;
    s_slot_valid = 4'b0001;
    rx_start = 1'b1;
    idle(1);
    for (int p = 0; p < 8; p++) begin
      logic h;
      h = (p >= 4 && p <= 6);
      s_slot_data[7:0] = 8'hA0 + 8'(p) - 8'd4;
      tick(1'b1, p == 0, 16'(p), h, s_slot_data[7:0], {3'b000, h});
    end
    rx_end = 1'b1;
    idle(1);
    chk({tag, "_done"}, 32'(slot_done), 32'h1);
    chk({tag, "_underrun"}, 32'(slot_underrun), 32'h0);
    idle(1);
    chk({tag, "_done_pulse"}, 32'(slot_done), 32'h0);
    idle(LAT);
  endtask

  initial begin
    rst = 1'b0;
    slot_enable = '0; slot_type = '0; slot_offset = '0; slot_size = '0;
    s_slot_data = '0; s_slot_valid = '0;
    rx_start = 1'b0; rx_end = 1'b0; rx_error = 1'b0; rx_type = 8'h00;
    payload_first = 1'b0; payload_pos = 16'h0; payload_valid = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    mon_en = 1'b1;
    rst    = 1'b1;
    chk("rst_replace_valid", 32'(replace_valid), 32'h0);
    chk("rst_replace_data", 32'(replace_data), 32'h0);
    chk("rst_done", 32'(slot_done), 32'h0);
    chk("rst_abort", 32'(slot_abort), 32'h0);
    chk("rst_underrun", 32'(slot_underrun), 32'h0);

    // Single window, bytes A0..A2 at pos 4..6
    run_basic("t1");

    // Overlap: slot0 owns 0..3, slot1 takes 4..5 after slot0's window ends
    set_slot(0, 1'b1, 8'h10, 16'd0, 16'd4);
    set_slot(1, 1'b1, 8'h10, 16'd2, 16'd4);
    s_slot_valid = 4'b0011;
    rx_start = 1'b1;
    idle(1);
    for (int p = 0; p < 8; p++) begin
      logic e0, e1;
      e0 = (p < 4);
      e1 = !e0 && (p >= 2) && (p < 6);
      s_slot_data = {16'h0000, 8'hC0 + 8'(p), 8'hB0 + 8'(p)};
      tick(1'b1, p == 0, 16'(p), e0 | e1, e0 ? 8'hB0 + 8'(p) : 8'hC0 + 8'(p),
           {2'b00, e1, e0});
    end
    rx_end = 1'b1;
    idle(1);
    chk("t2_done", 32'(slot_done), 32'h3);
    idle(LAT);

    // Underrun at pos5 of window 4..6
    set_slot(0, 1'b1, 8'h10, 16'd4, 16'd3);
    slot_enable[1] = 1'b0;
    rx_start = 1'b1;
    idle(1);
    for (int p = 0; p < 8; p++) begin
      logic h;
      h = (p >= 4 && p <= 6);
      s_slot_valid     = (p == 5) ? 4'b0000 : 4'b0001;
      s_slot_data[7:0] = (p == 6) ? 8'hA1 : 8'hA0;
      tick(1'b1, p == 0, 16'(p), h && (p != 5), s_slot_data[7:0], {3'b000, h});
      if (p == 5) chk("t3_underrun_set", 32'(slot_underrun), 32'h1);
    end
    s_slot_valid = 4'b0001;
    rx_end = 1'b1;
    idle(1);
    chk("t3_done", 32'(slot_done), 32'h1);
    chk("t3_underrun_sticky", 32'(slot_underrun), 32'h1);
    rx_start = 1'b1;
    idle(1);
    chk("t3_underrun_clear", 32'(slot_underrun), 32'h0);

    // Error while window bytes are still in the delay line
    rx_start = 1'b1;
    idle(1);
    for (int p = 0; p < 6; p++) begin
      logic h;
      h = (p >= 4);
      s_slot_data[7:0] = 8'hA0 + 8'(p) - 8'd4;
      tick(1'b1, p == 0, 16'(p), h, s_slot_data[7:0], {3'b000, h});
    end
    rx_error = 1'b1;
    idle(1);
    chk("t4_abort", 32'(slot_abort), 32'h1);
    chk("t4_no_done", 32'(slot_done), 32'h0);
    idle(1);
    chk("t4_abort_pulse", 32'(slot_abort), 32'h0);
    idle(LAT);

    // Type mismatch, then size 0, then a window at the top of the position range
    for (int t = 0; t < 3; t++) begin
      if (t == 0) set_slot(0, 1'b1, 8'h10, 16'h0000, 16'd8);
      if (t == 1) set_slot(0, 1'b1, 8'h11, 16'h0000, 16'd0);
      if (t == 2) set_slot(0, 1'b1, 8'h11, 16'hFFFE, 16'd4);
      rx_type  = 8'h11;
      rx_start = 1'b1;
      idle(1);
      for (int i = 0; i < 6; i++) begin
        logic h;
        h = (t == 2) && (i == 2 || i == 3);
        s_slot_data[7:0] = 8'hD0 + 8'(i);
        tick(1'b1, i == 0, 16'hFFFC + 16'(i), h, s_slot_data[7:0], {3'b000, h});
      end
      rx_end = 1'b1;
      idle(1);
      chk("t5_done", 32'(slot_done), (t == 2) ? 32'h1 : 32'h0);
      idle(LAT);
    end

    // Reset pulse mid-window: rest of the packet passes through untouched
    set_slot(0, 1'b1, 8'h10, 16'd4, 16'd3);
    rx_type  = 8'h10;
    rx_start = 1'b1;
    idle(1);
    for (int p = 0; p < 8; p++) begin
      if (p == 5) rst = 1'b0;
      s_slot_data[7:0] = 8'hA0 + 8'(p) - 8'd4;
      tick(1'b1, p == 0, 16'(p), p == 4, s_slot_data[7:0], {3'b000, p == 4});
      if (p == 5) begin
        rst = 1'b1;
        chk("t6_done", 32'(slot_done), 32'h0);
        chk("t6_abort", 32'(slot_abort), 32'h0);
        chk("t6_underrun", 32'(slot_underrun), 32'h0);
      end
    end
    rx_end = 1'b1;
    idle(1);
    chk("t6_no_done", 32'(slot_done), 32'h0);
    idle(LAT);
    run_basic("t6b");

    idle(LAT + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
